// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one mmu command port between instruction fetch (port 0)
// and data load/store (port 1), with a post-reset drain period and a hung-mmu timeout.
module mmu_arbiter #(
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned DRAIN       = 8,
    parameter logic [3:0]  ERR_TIMEOUT = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_p0_req,
    input  logic [3:0]  i_p0_cmd,
    input  logic [31:0] i_p0_vaddr,
    input  logic [31:0] i_p0_data,
    input  logic [1:0]  i_p0_size,
    input  logic        i_p0_user,
    output logic        o_p0_done,
    output logic [31:0] o_p0_data,
    output logic [3:0]  o_p0_error,
    input  logic        i_p1_req,
    input  logic [3:0]  i_p1_cmd,
    input  logic [31:0] i_p1_vaddr,
    input  logic [31:0] i_p1_data,
    input  logic [1:0]  i_p1_size,
    input  logic        i_p1_user,
    output logic        o_p1_done,
    output logic [31:0] o_p1_data,
    output logic [3:0]  o_p1_error,
    output logic [31:0] o_m_vaddr,
    output logic [31:0] o_m_data,
    output logic [1:0]  o_m_size,
    output logic [3:0]  o_m_cmd,
    output logic        o_m_user,
    output logic        o_m_valid,
    input  logic [31:0] i_m_data,
    input  logic        i_m_valid,
    input  logic [3:0]  i_m_error,
    output logic        o_hung
);

    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN - 1);

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_drain_cnt, w_drain_cnt;
    logic [15:0] r_to_cnt, w_to_cnt;
    logic        r_owner, w_owner;
    logic        r_last, w_last;
    logic        w_gnt, w_any_req, w_hung;
    logic        w_fin;
    logic [31:0] w_fin_data;
    logic [3:0]  w_fin_err;
    logic [3:0]  w_m_cmd;
    logic [31:0] w_m_vaddr, w_m_data;
    logic [1:0]  w_m_size;
    logic        w_m_user, w_m_valid;
    logic        w_p0_done, w_p1_done;
    logic [31:0] w_p0_data, w_p1_data;
    logic [3:0]  w_p0_error, w_p1_error;

    // Round-robin choice: on a tie the port not served last wins.
    always_comb begin
        w_any_req = i_p0_req | i_p1_req;
        if (i_p0_req && i_p1_req) begin
            w_gnt = ~r_last;
        end else if (i_p1_req) begin
            w_gnt = 1'b1;
        end else begin
            w_gnt = 1'b0;
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        w_state     = r_state;
        w_drain_cnt = r_drain_cnt;
        w_to_cnt    = r_to_cnt;
        w_owner     = r_owner;
        w_last      = r_last;
        w_hung      = o_hung;
        w_m_cmd     = o_m_cmd;
        w_m_vaddr   = o_m_vaddr;
        w_m_data    = o_m_data;
        w_m_size    = o_m_size;
        w_m_user    = o_m_user;
        w_m_valid   = 1'b0;
        w_fin       = 1'b0;
        w_fin_data  = 32'h0000_0000;
        w_fin_err   = 4'h0;
        case (r_state)
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state     = ST_IDLE;
                    w_drain_cnt = 16'd0;
                end else begin
                    w_drain_cnt = r_drain_cnt + 16'd1;
                end
            end
            ST_IDLE: begin
                if (o_hung) begin
                    w_state = ST_IDLE;
                end else if (w_any_req) begin
                    w_owner   = w_gnt;
                    w_last    = w_gnt;
                    w_m_cmd   = w_gnt ? i_p1_cmd   : i_p0_cmd;
                    w_m_vaddr = w_gnt ? i_p1_vaddr : i_p0_vaddr;
                    w_m_data  = w_gnt ? i_p1_data  : i_p0_data;
                    w_m_size  = w_gnt ? i_p1_size  : i_p0_size;
                    w_m_user  = w_gnt ? i_p1_user  : i_p0_user;
                    w_m_valid = 1'b1;
                    w_state   = ST_ISSUE;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_to_cnt = 16'd0;
                w_state  = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_m_valid) begin
                    w_fin      = 1'b1;
                    w_fin_data = i_m_data;
                    w_fin_err  = i_m_error;
                    w_state    = ST_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    // The mmu never answered: abort and lock out further grants.
                    w_fin      = 1'b1;
                    w_fin_data = 32'h0000_0000;
                    w_fin_err  = ERR_TIMEOUT;
                    w_hung     = 1'b1;
                    w_state    = ST_DONE;
                end else begin
                    w_to_cnt = r_to_cnt + 16'd1;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_DRAIN;
            end
        endcase
        w_p0_done  = w_fin & ~r_owner;
        w_p1_done  = w_fin & r_owner;
        w_p0_data  = (w_fin && !r_owner) ? w_fin_data : o_p0_data;
        w_p0_error = (w_fin && !r_owner) ? w_fin_err  : o_p0_error;
        w_p1_data  = (w_fin && r_owner)  ? w_fin_data : o_p1_data;
        w_p1_error = (w_fin && r_owner)  ? w_fin_err  : o_p1_error;
    end

    // Sequencer state, counters and arbitration history.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 16'd0;
            r_to_cnt    <= 16'd0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_drain_cnt <= w_drain_cnt;
            r_to_cnt    <= w_to_cnt;
            r_owner     <= w_owner;
            r_last      <= w_last;
        end
    end

    // Registered outputs toward the mmu and both requesters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_m_cmd    <= 4'h0;
            o_m_vaddr  <= 32'h0000_0000;
            o_m_data   <= 32'h0000_0000;
            o_m_size   <= 2'b00;
            o_m_user   <= 1'b0;
            o_m_valid  <= 1'b0;
            o_p0_done  <= 1'b0;
            o_p0_data  <= 32'h0000_0000;
            o_p0_error <= 4'h0;
            o_p1_done  <= 1'b0;
            o_p1_data  <= 32'h0000_0000;
            o_p1_error <= 4'h0;
            o_hung     <= 1'b0;
        end else begin
            o_m_cmd    <= w_m_cmd;
            o_m_vaddr  <= w_m_vaddr;
            o_m_data   <= w_m_data;
            o_m_size   <= w_m_size;
            o_m_user   <= w_m_user;
            o_m_valid  <= w_m_valid;
            o_p0_done  <= w_p0_done;
            o_p0_data  <= w_p0_data;
            o_p0_error <= w_p0_error;
            o_p1_done  <= w_p1_done;
            o_p1_data  <= w_p1_data;
            o_p1_error <= w_p1_error;
            o_hung     <= w_hung;
        end
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed self-checking bench for mmu_arbiter with a small mmu response stub.
module tb_mmu_arbiter;

    localparam logic [3:0] MMU_READ   = 4'h1;
    localparam logic [3:0] MMU_WRITE  = 4'h2;
    localparam logic [3:0] MMU_FWPAGE = 4'h3;

    logic        i_clk, i_reset;
    logic        i_p0_req, i_p0_user, i_p1_req, i_p1_user;
    logic [3:0]  i_p0_cmd, i_p1_cmd;
    logic [31:0] i_p0_vaddr, i_p0_data, i_p1_vaddr, i_p1_data;
    logic [1:0]  i_p0_size, i_p1_size;
    logic        o_p0_done, o_p1_done;
    logic [31:0] o_p0_data, o_p1_data;
    logic [3:0]  o_p0_error, o_p1_error;
    logic [31:0] o_m_vaddr, o_m_data;
    logic [1:0]  o_m_size;
    logic [3:0]  o_m_cmd;
    logic        o_m_user, o_m_valid;
    logic [31:0] i_m_data;
    logic        i_m_valid;
    logic [3:0]  i_m_error;
    logic        o_hung;

    int n_checks = 0;
    int n_errors = 0;
    int p1_done_cnt = 0;
    logic       stub_en = 1'b1;
    int         stub_delay = 1;
    logic [3:0] stub_err = 4'h0;

    mmu_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_p0_req(i_p0_req), .i_p0_cmd(i_p0_cmd), .i_p0_vaddr(i_p0_vaddr),
        .i_p0_data(i_p0_data), .i_p0_size(i_p0_size), .i_p0_user(i_p0_user),
        .o_p0_done(o_p0_done), .o_p0_data(o_p0_data), .o_p0_error(o_p0_error),
        .i_p1_req(i_p1_req), .i_p1_cmd(i_p1_cmd), .i_p1_vaddr(i_p1_vaddr),
        .i_p1_data(i_p1_data), .i_p1_size(i_p1_size), .i_p1_user(i_p1_user),
        .o_p1_done(o_p1_done), .o_p1_data(o_p1_data), .o_p1_error(o_p1_error),
        .o_m_vaddr(o_m_vaddr), .o_m_data(o_m_data), .o_m_size(o_m_size),
        .o_m_cmd(o_m_cmd), .o_m_user(o_m_user), .o_m_valid(o_m_valid),
        .i_m_data(i_m_data), .i_m_valid(i_m_valid), .i_m_error(i_m_error),
        .o_hung(o_hung)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_p1_done) p1_done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_m_valid) return;
            if (cyc >= limit) begin
                cyc = -1;
                return;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int port, output int cyc);
        cyc = 0;
        port = -1;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_p0_done) begin
                port = 0;
                return;
            end
            if (o_p1_done) begin
                port = 1;
                return;
            end
            if (cyc >= limit) return;
        end
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        i_p0_req = 1'b0;
        i_p1_req = 1'b0;
        tick(2);
        check("rst_m_valid", 32'(o_m_valid), 32'd0);
        check("rst_m_vaddr", o_m_vaddr, 32'd0);
        check("rst_p0_done", 32'(o_p0_done), 32'd0);
        check("rst_p1_data", o_p1_data, 32'd0);
        check("rst_hung", 32'(o_hung), 32'd0);
        i_reset = 1'b0;
    endtask

    // mmu stub: answers a command stub_delay cycles after o_m_valid and checks o_m_* stay put.
    initial begin
        logic [70:0] cap;
        logic [31:0] cap_vaddr;
        logic        ok;
        i_m_valid = 1'b0;
        i_m_data  = 32'd0;
        i_m_error = 4'd0;
        forever begin
            @(negedge i_clk);
            if (o_m_valid && stub_en) begin
                cap       = {o_m_cmd, o_m_vaddr, o_m_data, o_m_size, o_m_user};
                cap_vaddr = o_m_vaddr;
                ok        = 1'b1;
                for (int i = 0; i < stub_delay; i++) begin
                    @(negedge i_clk);
                    if ({o_m_cmd, o_m_vaddr, o_m_data, o_m_size, o_m_user} !== cap) ok = 1'b0;
                end
                i_m_data  = {16'hC0DE, cap_vaddr[15:0]};
                i_m_error = stub_err;
                i_m_valid = 1'b1;
                @(negedge i_clk);
                i_m_valid = 1'b0;
                check("m_fields_stable", 32'(ok), 32'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, port, n0, n1;
        i_reset = 1'b1;
        i_p0_req = 1'b0; i_p0_cmd = 4'h0; i_p0_vaddr = 32'd0; i_p0_data = 32'd0;
        i_p0_size = 2'b00; i_p0_user = 1'b0;
        i_p1_req = 1'b0; i_p1_cmd = 4'h0; i_p1_vaddr = 32'd0; i_p1_data = 32'd0;
        i_p1_size = 2'b00; i_p1_user = 1'b0;

        // Test 1: first grant only after drain, single READ completes on port 0.
        do_reset();
        i_p0_cmd = MMU_READ; i_p0_vaddr = 32'h0000_0100; i_p0_size = 2'b11; i_p0_req = 1'b1;
        stub_delay = 1; stub_err = 4'h0;
        wait_valid(40, cyc);
        check("t1_first_grant_lat", 32'(cyc), 32'd9);
        check("t1_m_vaddr", o_m_vaddr, 32'h0000_0100);
        tick(1);
        check("t1_valid_one_cycle", 32'(o_m_valid), 32'd0);
        wait_done(40, port, cyc);
        check("t1_done_port", 32'(port), 32'd0);
        check("t1_done_lat", 32'(cyc), 32'd1);
        check("t1_p0_data", o_p0_data, 32'hC0DE_0100);
        check("t1_p0_err", 32'(o_p0_error), 32'd0);
        i_p0_req = 1'b0;
        tick(1);
        check("t1_done_pulse", 32'(o_p0_done), 32'd0);
        check("t1_p1_no_done", 32'(p1_done_cnt), 32'd0);

        // Test 2: both ports hold requests, grants alternate starting with port 0.
        do_reset();
        i_p0_cmd = MMU_READ;  i_p0_vaddr = 32'h0000_1000; i_p0_size = 2'b11;
        i_p1_cmd = MMU_WRITE; i_p1_vaddr = 32'h0000_2000; i_p1_data = 32'h55AA_55AA; i_p1_size = 2'b01;
        i_p0_req = 1'b1; i_p1_req = 1'b1;
        stub_delay = 2;
        n0 = 0; n1 = 0;
        for (int t = 0; t < 6; t++) begin
            wait_done(60, port, cyc);
            check("t2_grant_order", 32'(port), 32'(t % 2));
            if (port == 0) begin
                n0++;
                check("t2_p0_data", o_p0_data, 32'hC0DE_1000);
                if (n0 == 3) i_p0_req = 1'b0;
            end else if (port == 1) begin
                n1++;
                check("t2_p1_data", o_p1_data, 32'hC0DE_2000);
                if (n1 == 3) i_p1_req = 1'b0;
            end else begin
                break;
            end
        end
        i_p0_req = 1'b0; i_p1_req = 1'b0;

        // Test 3: slow WRITE on port 1, error code forwarded, port 0 result held.
        i_p1_cmd = MMU_WRITE; i_p1_vaddr = 32'h0000_2004; i_p1_data = 32'h1234_5678;
        i_p1_size = 2'b01; i_p1_user = 1'b1; i_p1_req = 1'b1;
        stub_delay = 5; stub_err = MMU_FWPAGE;
        wait_valid(20, cyc);
        check("t3_m_vaddr", o_m_vaddr, 32'h0000_2004);
        check("t3_m_data", o_m_data, 32'h1234_5678);
        check("t3_m_size", 32'(o_m_size), 32'd1);
        check("t3_m_cmd", 32'(o_m_cmd), 32'(MMU_WRITE));
        check("t3_m_user", 32'(o_m_user), 32'd1);
        wait_done(40, port, cyc);
        check("t3_done_port", 32'(port), 32'd1);
        check("t3_done_lat", 32'(cyc), 32'd6);
        check("t3_p1_err", 32'(o_p1_error), 32'(MMU_FWPAGE));
        check("t3_p1_data", o_p1_data, 32'hC0DE_2004);
        check("t3_p0_data_held", o_p0_data, 32'hC0DE_1000);
        i_p1_req = 1'b0; i_p1_user = 1'b0;

        // Test 4: mmu never answers, timeout aborts and locks out port 1.
        stub_en = 1'b0;
        i_p0_vaddr = 32'h0000_4000; i_p0_req = 1'b1;
        wait_valid(20, cyc);
        wait_done(120, port, cyc);
        check("t4_done_port", 32'(port), 32'd0);
        check("t4_timeout_lat", 32'(cyc), 32'd65);
        check("t4_err", 32'(o_p0_error), 32'hF);
        check("t4_data", o_p0_data, 32'd0);
        check("t4_hung", 32'(o_hung), 32'd1);
        i_p0_req = 1'b0; i_p1_req = 1'b1;
        wait_valid(30, cyc);
        check("t4_no_grant_hung", 32'(cyc), 32'hFFFF_FFFF);
        check("t4_p1_no_done", 32'(o_p1_done), 32'd0);

        // Test 5: reset during WAIT, then a fresh request completes after drain.
        do_reset();
        i_p0_vaddr = 32'h0000_5000; i_p0_req = 1'b1;
        wait_valid(40, cyc);
        tick(2);
        i_reset = 1'b1;
        tick(1);
        check("t5_rst_m_valid", 32'(o_m_valid), 32'd0);
        check("t5_rst_m_vaddr", o_m_vaddr, 32'd0);
        check("t5_rst_m_cmd", 32'(o_m_cmd), 32'd0);
        check("t5_rst_p0_done", 32'(o_p0_done), 32'd0);
        i_reset = 1'b0;
        stub_en = 1'b1; stub_delay = 1; stub_err = 4'h0;
        wait_valid(40, cyc);
        check("t5_drain_lat", 32'(cyc), 32'd9);
        check("t5_m_vaddr", o_m_vaddr, 32'h0000_5000);
        wait_done(40, port, cyc);
        check("t5_done_port", 32'(port), 32'd0);
        check("t5_done_lat", 32'(cyc), 32'd2);
        check("t5_p0_data", o_p0_data, 32'hC0DE_5000);
        i_p0_req = 1'b0;

        // Test 6: request held after done with new fields; issued after the DONE cycle.
        i_p1_cmd = MMU_READ; i_p1_vaddr = 32'h0000_3000; i_p1_size = 2'b11; i_p1_req = 1'b1;
        wait_valid(20, cyc);
        wait_done(40, port, cyc);
        check("t6_done_port", 32'(port), 32'd1);
        i_p1_cmd = MMU_WRITE; i_p1_vaddr = 32'h0000_3040; i_p1_data = 32'hCAFE_F00D;
        wait_valid(10, cyc);
        check("t6_regrant_lat", 32'(cyc), 32'd2);
        check("t6_m_vaddr", o_m_vaddr, 32'h0000_3040);
        check("t6_m_data", o_m_data, 32'hCAFE_F00D);
        check("t6_m_cmd", 32'(o_m_cmd), 32'(MMU_WRITE));
        wait_done(40, port, cyc);
        check("t6_done2_port", 32'(port), 32'd1);
        check("t6_p1_data", o_p1_data, 32'hC0DE_3040);
        i_p1_req = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
